// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan decoder: active-low segment
// patterns (bit0=a .. bit6=g) and the per-sample tracking states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1011000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    // Some display drivers render 7 with segments a,b,c only.
    localparam logic [6:0] SEG_7_ALT = 7'b1111000;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoder.
// Define SEG7_DEC_ALT7_EN to also accept the three-segment form of 7.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       legal,
    output logic       blank,
    output logic [3:0] nibble
);

`ifdef SEG7_DEC_ALT7_EN
    localparam bit ALT7_EN = 1'b1;
`else
    localparam bit ALT7_EN = 1'b0;
`endif

    always_comb begin
        legal  = 1'b1;
        blank  = 1'b0;
        nibble = 4'h0;
        case (seg_n)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default: begin
                if (ALT7_EN && (seg_n == SEG_7_ALT)) begin
                    nibble = 4'h7;
                end else begin
                    legal = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers per-digit hex values.
// Optional: SEG7_DEC_ALT7_EN (handled in seg7_pattern_decode) accepts the a,b,c-only 7.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    upd_valid,
    output logic [IDXW-1:0]         upd_idx,
    output logic [3:0]              upd_val,
    output logic                    err
);

    localparam int CNTW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

    logic [NUM_DIGITS+6:0] in_sample;
    logic [NUM_DIGITS+6:0] s_q;
    logic                  in_onehot;
    state_t                state, state_nxt;
    logic [CNTW-1:0]       cnt, cnt_nxt;
    logic                  commit;
    logic [IDXW-1:0]       q_idx;
    logic                  dec_legal, dec_blank;
    logic [3:0]            dec_nibble;

    function automatic logic [IDXW-1:0] sel_to_idx(input logic [NUM_DIGITS-1:0] sel);
        sel_to_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) sel_to_idx = IDXW'(i);
        end
    endfunction

    assign in_sample = {dig_sel, seg_n};
    assign in_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - SEL_ONE)) == '0);
    assign q_idx     = sel_to_idx(s_q[NUM_DIGITS+6:7]);

    seg7_pattern_decode u_decode (
        .seg_n  (s_q[6:0]),
        .legal  (dec_legal),
        .blank  (dec_blank),
        .nibble (dec_nibble)
    );

    // Commit fires on the edge that sees the held sample for the (STABLE_CYCLES+1)th time.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        if (!in_onehot) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if ((in_sample != s_q) || (state == IDLE)) begin
            state_nxt = TRACK;
            cnt_nxt   = CNT_ONE;
        end else if (state == TRACK) begin
            if (cnt >= CNT_MAX) begin
                commit    = 1'b1;
                state_nxt = HOLD;
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            s_q       <= '0;
            hex_out   <= '0;
            blank_out <= '1;
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            upd_val   <= 4'h0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            s_q       <= in_sample;
            upd_valid <= 1'b0;
            err       <= err & ~err_clr;
            // A new error outranks a simultaneous clear.
            if (commit) begin
                if (dec_legal) begin
                    hex_out[{q_idx, 2'b00} +: 4] <= dec_nibble;
                    blank_out[q_idx]             <= 1'b0;
                    upd_valid                    <= 1'b1;
                    upd_idx                      <= q_idx;
                    upd_val                      <= dec_nibble;
                end else if (dec_blank) begin
                    blank_out[q_idx] <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed plus randomized bench for seg7_scan_decoder against a run-length
// reference model (a pattern commits when it has been seen on STABLE_CYCLES+1 consecutive edges).
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  dig_sel;
    logic        err_clr;
    logic [15:0] hex_out;
    logic [3:0]  blank_out;
    logic        upd_valid;
    logic [1:0]  upd_idx;
    logic [3:0]  upd_val;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [6:0] legal_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic [15:0] m_hex;
    logic [3:0]  m_blank;
    logic        m_err;
    logic        m_valid;
    logic [1:0]  m_idx;
    logic [3:0]  m_val;
    logic [10:0] m_last;
    bit          m_last_ok;
    int          m_run;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .dig_sel   (dig_sel),
        .err_clr   (err_clr),
        .hex_out   (hex_out),
        .blank_out (blank_out),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_val   (upd_val),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic bit refDecode(input logic [6:0] s, output logic [3:0] v);
        v = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (legal_tab[i] == s) begin
                v = 4'(i);
                return 1'b1;
            end
        end
`ifdef SEG7_DEC_ALT7_EN
        if (s == 7'b1111000) begin
            v = 4'h7;
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("upd_valid", {15'b0, upd_valid}, {15'b0, m_valid});
        if (m_valid) begin
            checkVal("upd_idx", {14'b0, upd_idx}, {14'b0, m_idx});
            checkVal("upd_val", {12'b0, upd_val}, {12'b0, m_val});
        end
        checkVal("hex_out", hex_out, m_hex);
        checkVal("blank_out", {12'b0, blank_out}, {12'b0, m_blank});
        checkVal("err", {15'b0, err}, {15'b0, m_err});
    endtask

    // One clock edge: drive inputs, advance the reference model for that edge, then compare.
    task automatic applyStimulus(input logic [3:0] d, input logic [6:0] s,
                                 input logic clr, input logic r);
        logic [3:0] v;
        bit         ok;
        int         idx;
        logic       nerr;
        dig_sel = d;
        seg_n   = s;
        err_clr = clr;
        rst     = r;
        @(posedge clk);
        m_valid = 1'b0;
        if (r) begin
            m_hex = '0; m_blank = '1; m_err = 1'b0;
            m_idx = '0; m_val = '0;
            m_run = 0; m_last_ok = 1'b0;
        end else begin
            nerr = m_err & ~clr;
            if ($countones(d) == 1) begin
                if (m_last_ok && (m_last == {d, s})) m_run++;
                else m_run = 1;
                m_last    = {d, s};
                m_last_ok = 1'b1;
            end else begin
                m_run     = 0;
                m_last_ok = 1'b0;
            end
            if (m_run == SC + 1) begin
                idx = $clog2(d);
                ok  = refDecode(s, v);
                if (ok) begin
                    m_hex[idx*4 +: 4] = v;
                    m_blank[idx]      = 1'b0;
                    m_valid           = 1'b1;
                    m_idx             = 2'(idx);
                    m_val             = v;
                end else if (s == 7'b1111111) begin
                    m_blank[idx] = 1'b1;
                end else begin
                    nerr = 1'b1;
                end
            end
            m_err = nerr;
        end
        #1;
        checkOutput();
    endtask

    initial begin
        logic [3:0] rd;
        logic [6:0] rs;
        int         k;
        int         len;
        logic [6:0] scan_pat [4];

        m_hex = '0; m_blank = '1; m_err = 1'b0; m_valid = 1'b0;
        m_idx = '0; m_val = '0; m_last = '0; m_last_ok = 1'b0; m_run = 0;
        dig_sel = '0; seg_n = 7'h7F; err_clr = 1'b0; rst = 1'b1;

        applyStimulus(4'b0000, 7'b1111111, 1'b0, 1'b1);
        applyStimulus(4'b0000, 7'b1111111, 1'b0, 1'b1);
        checkVal("reset_blank", {12'b0, blank_out}, 16'h000F);

        // Digit 0 showing 2: pulse after the fifth edge.
        for (int i = 0; i < SC + 1; i++) applyStimulus(4'b0001, 7'b0100100, 1'b0, 1'b0);
        checkVal("t1_valid", {15'b0, upd_valid}, 16'h0001);
        checkVal("t1_val", {12'b0, upd_val}, 16'h0002);
        checkVal("t1_hex", hex_out, 16'h0002);
        applyStimulus(4'b0001, 7'b0100100, 1'b0, 1'b0);
        checkVal("t1_single_pulse", {15'b0, upd_valid}, 16'h0000);

        scan_pat[0] = 7'b0001000; scan_pat[1] = 7'b0000011;
        scan_pat[2] = 7'b1000110; scan_pat[3] = 7'b0100001;
        for (int dg = 0; dg < 4; dg++)
            for (int i = 0; i < SC; i++)
                applyStimulus(4'(1 << dg), scan_pat[dg], 1'b0, 1'b0);
        checkVal("short_scan_hex", hex_out, 16'h0002);
        for (int dg = 0; dg < 4; dg++)
            for (int i = 0; i < SC + 2; i++)
                applyStimulus(4'(1 << dg), scan_pat[dg], 1'b0, 1'b0);
        checkVal("scan_hex", hex_out, 16'hDCBA);

        for (int i = 0; i < 10; i++) applyStimulus(4'b0011, 7'b0010010, 1'b0, 1'b0);
        checkVal("multihot_hex", hex_out, 16'hDCBA);

        for (int i = 0; i < SC + 1; i++) applyStimulus(4'b0100, 7'b1010101, 1'b0, 1'b0);
        checkVal("illegal_err", {15'b0, err}, 16'h0001);
        checkVal("illegal_hex", hex_out, 16'hDCBA);
        for (int i = 0; i < SC; i++) applyStimulus(4'b0100, 7'b0101010, 1'b0, 1'b0);
        applyStimulus(4'b0100, 7'b0101010, 1'b1, 1'b0);
        checkVal("clr_vs_set", {15'b0, err}, 16'h0001);
        applyStimulus(4'b0100, 7'b0101010, 1'b1, 1'b0);
        checkVal("clr_alone", {15'b0, err}, 16'h0000);

        for (int i = 0; i < SC + 1; i++) applyStimulus(4'b0010, 7'b1111111, 1'b0, 1'b0);
        checkVal("blank_d1", {15'b0, blank_out[1]}, 16'h0001);

        for (int i = 0; i < SC + 2; i++) applyStimulus(4'b1000, 7'b1111000, 1'b0, 1'b0);
`ifdef SEG7_DEC_ALT7_EN
        checkVal("alt7_hex", {12'b0, hex_out[15:12]}, 16'h0007);
`else
        checkVal("alt7_err", {15'b0, err}, 16'h0001);
`endif

        for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 7'b0010000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 7'b0010000, 1'b0, 1'b1);
        checkVal("abort_hex", hex_out, 16'h0000);
        checkVal("abort_blank", {12'b0, blank_out}, 16'h000F);
        for (int i = 0; i < 8; i++) applyStimulus(4'b0000, 7'b0010000, 1'b0, 1'b0);

        // Random runs: mostly one-hot digits and legal patterns, with varied hold lengths.
        for (int r = 0; r < 60; r++) begin
            k  = $urandom_range(0, 9);
            rd = (k == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
            k  = $urandom_range(0, 9);
            if (k < 7)      rs = legal_tab[$urandom_range(0, 15)];
            else if (k < 8) rs = 7'b1111111;
            else            rs = 7'($urandom);
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++)
                applyStimulus(rd, rs, ($urandom_range(0, 7) == 0), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
